// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//   Timing and user-control sequencer for the clock. Produces the 1 Hz seconds
//   tick in RUN and drives a button FSM (RUN -> SET_H -> SET_M -> RUN) that
//   suppresses the tick and issues single or auto-repeat increments to the
//   hour or minute counter. This block is the only source of increment pulses
//   into the counter chain.
//
//   Optional feature macro: CLOCK_SET_DEBOUNCE_EN (adds a per-button debouncer
//   after the synchronizer; DEB_CYCLES is otherwise unused).
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous, active-low reset
//   i_btn_mode   raw asynchronous mode button, active-high
//   i_btn_inc    raw asynchronous increment button, active-high
//   o_inc_sec    1-cycle pulse, seconds +1 (RUN only)
//   o_inc_min    1-cycle pulse, minutes +1 (SET_M only)
//   o_inc_hour   1-cycle pulse, hours +1 (SET_H only)
//   o_clr_sec    1-cycle pulse, clear seconds (on SET_M -> RUN)
//   o_mode       00 RUN, 01 SET_H, 10 SET_M
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned REPEAT_DIV  = 12500000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 1000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    output logic       o_inc_sec,
    output logic       o_inc_min,
    output logic       o_inc_hour,
    output logic       o_clr_sec,
    output logic [1:0] o_mode
);

    localparam int unsigned TickW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RepW  = $clog2(2 * REPEAT_DIV);

    localparam logic [TickW-1:0] TickLast  = TickW'(TICK_DIV - 1);
    localparam logic [RepW-1:0]  RepFirst  = RepW'(2 * REPEAT_DIV - 1);
    localparam logic [RepW-1:0]  RepReload = RepW'(REPEAT_DIV);

    if (TICK_DIV < 2 || REPEAT_DIV < 2 || SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_bad_param
        $error("clock_set_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        StRun  = 2'b00,
        StSetH = 2'b01,
        StSetM = 2'b10
    } state_t;

    // Button index 0 = mode, 1 = inc.
    logic [1:0]             w_btn;
    logic [SYNC_STAGES-1:0] r_sync [2];
    logic [1:0]             w_sync;
    logic [1:0]             w_lvl;
    logic [1:0]             r_prev;
    logic [1:0]             w_rise;

    assign w_btn = {i_btn_inc, i_btn_mode};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int b = 0; b < 2; b++) begin
                r_sync[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_sync[b] <= {r_sync[b][SYNC_STAGES-2:0], w_btn[b]};
            end
        end
    end

    always_comb begin
        w_sync = '0;
        for (int b = 0; b < 2; b++) begin
            w_sync[b] = r_sync[b][SYNC_STAGES-1];
        end
    end

`ifdef CLOCK_SET_DEBOUNCE_EN
    localparam int unsigned      DebW    = $clog2(DEB_CYCLES + 1);
    localparam logic [DebW-1:0]  DebLast = DebW'(DEB_CYCLES - 1);

    logic [DebW-1:0] r_deb_cnt [2];
    logic [1:0]      r_deb_lvl;

    // Accepted level moves only after the synchronized level has disagreed
    // with it for DEB_CYCLES consecutive cycles; any return resets the count.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_deb_lvl <= '0;
            for (int b = 0; b < 2; b++) begin
                r_deb_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_sync[b] == r_deb_lvl[b]) begin
                    r_deb_cnt[b] <= '0;
                end else if (r_deb_cnt[b] == DebLast) begin
                    r_deb_lvl[b] <= w_sync[b];
                    r_deb_cnt[b] <= '0;
                end else begin
                    r_deb_cnt[b] <= r_deb_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign w_lvl = r_deb_lvl;
`else
    assign w_lvl = w_sync;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_lvl;
        end
    end

    assign w_rise = w_lvl & ~r_prev;

    logic w_mode_rise;
    logic w_inc_rise;
    logic w_inc_lvl;

    assign w_mode_rise = w_rise[0];
    assign w_inc_rise  = w_rise[1];
    assign w_inc_lvl   = w_lvl[1];

    state_t           r_state;
    logic [TickW-1:0] r_tick_cnt;
    logic [RepW-1:0]  r_rep_cnt;
    logic             r_rep_en;
    logic             r_inc_sec;
    logic             r_inc_min;
    logic             r_inc_hour;
    logic             r_clr_sec;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= StRun;
            r_tick_cnt <= '0;
            r_rep_cnt  <= '0;
            r_rep_en   <= 1'b0;
            r_inc_sec  <= 1'b0;
            r_inc_min  <= 1'b0;
            r_inc_hour <= 1'b0;
            r_clr_sec  <= 1'b0;
        end else begin
            r_inc_sec  <= 1'b0;
            r_inc_min  <= 1'b0;
            r_inc_hour <= 1'b0;
            r_clr_sec  <= 1'b0;
            case (r_state)
                StRun: begin
                    r_rep_en  <= 1'b0;
                    r_rep_cnt <= '0;
                    if (w_mode_rise) begin
                        // Leaving RUN: the tick is dropped so no inc_sec
                        // appears alongside a set-mode state.
                        r_state    <= StSetH;
                        r_tick_cnt <= '0;
                    end else if (r_tick_cnt == TickLast) begin
                        r_tick_cnt <= '0;
                        r_inc_sec  <= 1'b1;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                StSetH, StSetM: begin
                    r_tick_cnt <= '0;
                    if (w_mode_rise) begin
                        // Mode wins over a coincident inc edge; repeat is
                        // disarmed until the next accepted inc press.
                        r_state   <= (r_state == StSetH) ? StSetM : StRun;
                        r_clr_sec <= (r_state == StSetM);
                        r_rep_en  <= 1'b0;
                        r_rep_cnt <= '0;
                    end else if (w_inc_rise) begin
                        r_inc_hour <= (r_state == StSetH);
                        r_inc_min  <= (r_state == StSetM);
                        r_rep_en   <= 1'b1;
                        r_rep_cnt  <= '0;
                    end else if (r_rep_en && w_inc_lvl) begin
                        // First repeat after 2*REPEAT_DIV, later ones every
                        // REPEAT_DIV: reload to REPEAT_DIV after each pulse.
                        if (r_rep_cnt == RepFirst) begin
                            r_inc_hour <= (r_state == StSetH);
                            r_inc_min  <= (r_state == StSetM);
                            r_rep_cnt  <= RepReload;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end else begin
                        r_rep_en  <= 1'b0;
                        r_rep_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= StRun;
                    r_tick_cnt <= '0;
                    r_rep_en   <= 1'b0;
                    r_rep_cnt  <= '0;
                end
            endcase
        end
    end

    assign o_inc_sec  = r_inc_sec;
    assign o_inc_min  = r_inc_min;
    assign o_inc_hour = r_inc_hour;
    assign o_clr_sec  = r_clr_sec;
    assign o_mode     = r_state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
//   Self-checking bench for clock_set_ctrl. A cycle-indexed reference model
//   derives the accepted button levels from the raw input history, then
//   applies the tick/mode/increment rules with plain arithmetic. Every output
//   is compared after every clock edge, plus directed checks for the
//   latency, repeat timing and clear-to-tick spacing.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

    localparam int TD   = 10;
    localparam int RD   = 4;
    localparam int SS   = 2;
    localparam int DC   = 3;
    localparam int MAXE = 20000;
`ifdef CLOCK_SET_DEBOUNCE_EN
    localparam int DEB   = DC;
    localparam int PRESS = DC + 1;
`else
    localparam int DEB   = 0;
    localparam int PRESS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       inc_sec;
    logic       inc_min;
    logic       inc_hour;
    logic       clr_sec;
    logic [1:0] mode;

    clock_set_ctrl #(
        .TICK_DIV    (TD),
        .REPEAT_DIV  (RD),
        .SYNC_STAGES (SS),
        .DEB_CYCLES  (DC)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_btn_mode (btn_mode),
        .i_btn_inc  (btn_inc),
        .o_inc_sec  (inc_sec),
        .o_inc_min  (inc_min),
        .o_inc_hour (inc_hour),
        .o_clr_sec  (clr_sec),
        .o_mode     (mode)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int e     = 0;

    // Raw samples (index = edge number) and model-accepted levels.
    logic raw_m [MAXE];
    logic raw_i [MAXE];
    logic lvl_m [MAXE];
    logic lvl_i [MAXE];

    int   m_mode;
    int   run_start;
    int   press_e;
    bit   armed;
    logic x_sec, x_min, x_hour, x_clr;

    int   q_sec[$];
    int   q_min[$];
    int   q_hour[$];
    int   q_clr[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, e, obs, exp_v);
        end
    endtask

    // Synchronized level after edge t.
    function automatic logic sget(input bit b, input int t);
        int idx;
        idx = t - (SS - 1);
        if (idx < 1) return 1'b0;
        return b ? raw_i[idx] : raw_m[idx];
    endfunction

    function automatic logic lget(input bit b, input int t);
        if (t < 0) return 1'b0;
        return b ? lvl_i[t] : lvl_m[t];
    endfunction

    function automatic logic accept(input bit b, input int t);
`ifdef CLOCK_SET_DEBOUNCE_EN
        // A level is accepted once it has been seen DC cycles in a row.
        bit same;
        same = 1'b1;
        for (int j = 1; j <= DC; j++) begin
            if (sget(b, t - j) != sget(b, t - 1)) same = 1'b0;
        end
        return same ? sget(b, t - 1) : lget(b, t - 1);
`else
        return sget(b, t);
`endif
    endfunction

    task automatic model_reset();
        e         = 0;
        m_mode    = 0;
        run_start = 0;
        armed     = 1'b0;
        lvl_m[0]  = 1'b0;
        lvl_i[0]  = 1'b0;
    endtask

    task automatic step();
        logic mr, ir, il;
        int   k;
        e++;
        if (e >= MAXE) begin
            $display("FAIL edge_budget edge=%0d limit=%0d", e, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        raw_m[e] = btn_mode;
        raw_i[e] = btn_inc;
        @(posedge clk);
        lvl_m[e] = accept(1'b0, e);
        lvl_i[e] = accept(1'b1, e);
        mr = lget(1'b0, e - 1) & ~lget(1'b0, e - 2);
        ir = lget(1'b1, e - 1) & ~lget(1'b1, e - 2);
        il = lget(1'b1, e - 1);
        x_sec = 1'b0; x_min = 1'b0; x_hour = 1'b0; x_clr = 1'b0;
        if (mr) begin
            x_clr     = (m_mode == 2);
            m_mode    = (m_mode + 1) % 3;
            run_start = e;
            armed     = 1'b0;
        end else if (m_mode == 0) begin
            x_sec = ((e - run_start) % TD == 0);
        end else if (ir) begin
            x_hour  = (m_mode == 1);
            x_min   = (m_mode == 2);
            press_e = e;
            armed   = 1'b1;
        end else if (armed && il) begin
            k = e - press_e;
            if (k >= 2 * RD && (k - 2 * RD) % RD == 0) begin
                x_hour = (m_mode == 1);
                x_min  = (m_mode == 2);
            end
        end else begin
            armed = 1'b0;
        end
        #1;
        chk("inc_sec", 32'(inc_sec), 32'(x_sec));
        chk("inc_min", 32'(inc_min), 32'(x_min));
        chk("inc_hour", 32'(inc_hour), 32'(x_hour));
        chk("clr_sec", 32'(clr_sec), 32'(x_clr));
        chk("mode", 32'(mode), 32'(m_mode));
        if (inc_sec)  q_sec.push_back(e);
        if (inc_min)  q_min.push_back(e);
        if (inc_hour) q_hour.push_back(e);
        if (clr_sec)  q_clr.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic press(input bit use_mode, input bit use_inc, input int hold);
        if (use_mode) btn_mode = 1'b1;
        if (use_inc)  btn_inc  = 1'b1;
        repeat (hold) step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic clear_q();
        q_sec.delete(); q_min.delete(); q_hour.delete(); q_clr.delete();
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int exp_off[5];
        int t_raw;
        int t_clr;
        int t_sec;
        exp_off = '{0, 8, 12, 16, 20};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inc_sec", 32'(inc_sec), 32'd0);
        chk("rst_inc_min", 32'(inc_min), 32'd0);
        chk("rst_inc_hour", 32'(inc_hour), 32'd0);
        chk("rst_clr_sec", 32'(clr_sec), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        release_rst();

        // Free-running ticks on edges 10, 20, 30.
        clear_q();
        idle(35);
        chk("tick_count", 32'(q_sec.size()), 32'd3);
        if (q_sec.size() == 3) begin
            chk("tick_first", 32'(q_sec[0]), 32'd10);
            chk("tick_third", 32'(q_sec[2]), 32'd30);
        end

        // RUN -> SET_H, tick suppressed.
        clear_q();
        press(1'b1, 1'b0, PRESS);
        idle(50);
        chk("seth_mode", 32'(mode), 32'd1);
        chk("seth_no_tick", 32'(q_sec.size()), 32'd0);

        // Single inc press: one inc_hour, SS+1 (+debounce) cycles after the rise.
        clear_q();
        t_raw = e;
        press(1'b0, 1'b1, PRESS);
        idle(15);
        chk("hour_count", 32'(q_hour.size()), 32'd1);
        if (q_hour.size() == 1) chk("hour_latency", 32'(q_hour[0] - t_raw), 32'(SS + 1 + DEB));

        // SET_M, held inc: pulses at +0, +8, +12, +16, +20 then silence.
        press(1'b1, 1'b0, PRESS);
        idle(10);
        clear_q();
        press(1'b0, 1'b1, 21);
        idle(20);
        chk("rep_count", 32'(q_min.size()), 32'd5);
        chk("rep_no_hour", 32'(q_hour.size()), 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i < q_min.size()) chk("rep_offset", 32'(q_min[i] - q_min[0]), 32'(exp_off[i]));
        end

        // SET_M -> RUN: clr_sec with mode 00, next tick exactly TD later.
        clear_q();
        press(1'b1, 1'b0, PRESS);
        idle(30);
        t_clr = (q_clr.size() > 0) ? q_clr[0] : -1000;
        t_sec = (q_sec.size() > 0) ? q_sec[0] : 0;
        chk("clr_count", 32'(q_clr.size()), 32'd1);
        chk("clr_to_tick", 32'(t_sec - t_clr), 32'(TD));

        // Coincident mode + inc in SET_H: mode wins, no increment.
        press(1'b1, 1'b0, PRESS);
        idle(8);
        clear_q();
        press(1'b1, 1'b1, PRESS + 12);
        idle(20);
        chk("tie_mode", 32'(mode), 32'd2);
        chk("tie_no_inc", 32'(q_hour.size() + q_min.size()), 32'd0);

        // Reset mid-repeat in SET_M: asynchronous clear.
        btn_inc = 1'b1;
        idle(14);
        rst = 1'b0;
        #1;
        chk("arst_inc_min", 32'(inc_min), 32'd0);
        chk("arst_inc_hour", 32'(inc_hour), 32'd0);
        chk("arst_inc_sec", 32'(inc_sec), 32'd0);
        chk("arst_clr_sec", 32'(clr_sec), 32'd0);
        chk("arst_mode", 32'(mode), 32'd0);
        btn_inc = 1'b0;
        repeat (2) @(posedge clk);
        release_rst();

`ifdef CLOCK_SET_DEBOUNCE_EN
        // Short glitch on inc in SET_H is filtered.
        press(1'b1, 1'b0, PRESS);
        idle(10);
        clear_q();
        press(1'b0, 1'b1, 2);
        idle(15);
        chk("glitch_no_hour", 32'(q_hour.size()), 32'd0);
`endif

        // Randomized button activity, checked cycle by cycle against the model.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: idle($urandom_range(1, 20));
                1: press(1'b1, 1'b0, $urandom_range(PRESS, PRESS + 3));
                2: press(1'b0, 1'b1, $urandom_range(PRESS, 30));
                default: press(1'b1, 1'b1, $urandom_range(PRESS, 10));
            endcase
            idle($urandom_range(PRESS + 3, 10));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
